// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target blocks.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef logic [7:0] i2c_byte_t;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Register write stream and debug read port of the I2C register-file target.
interface i2c_target_regfile_if #(
    parameter int unsigned AW = 4
);
    logic          reg_wr_en;
    logic [AW-1:0] reg_wr_addr;
    logic [7:0]    reg_wr_data;
    logic [AW-1:0] dbg_addr;
    logic [7:0]    dbg_data;
    logic          busy;
    logic          nack_seen;

    modport master (
        output reg_wr_en, reg_wr_addr, reg_wr_data, dbg_data, busy, nack_seen,
        input  dbg_addr
    );

    modport slave (
        input  reg_wr_en, reg_wr_addr, reg_wr_data, dbg_data, busy, nack_seen,
        output dbg_addr
    );
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers on SCL/SDA plus edge, START and STOP detection.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       scl_s, sda_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    // Idle bus is pulled high, so everything resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign sda_o     = sda_s;
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
    assign stop_det  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C register-file target at a fixed device address with auto-incrementing pointer.
// Optional SCL stretching before each read byte: define I2C_TARGET_STRETCH_EN.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = 7'h48,
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned STRETCH_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    inout  wire                    scl,
    inout  wire                    sda,
    i2c_target_regfile_if.master   rf
);
    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0
        || STRETCH_CYCLES > 65535) begin : g_param_check
        $error("i2c_target_regfile: illegal NUM_REGS or STRETCH_CYCLES");
    end

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst_n     (reset_n),
        .scl_i     (scl),
        .sda_i     (sda),
        .sda_o     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    i2c_byte_t     shreg_q, shreg_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          phase_q, phase_d;
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          reg_wr_en_q, reg_wr_en_d;
    logic [AW-1:0] reg_wr_addr_q, reg_wr_addr_d;
    i2c_byte_t     reg_wr_data_q, reg_wr_data_d;
    logic          nack_seen_q, nack_seen_d;
    i2c_byte_t     regs_q [NUM_REGS];
    i2c_byte_t     regs_d [NUM_REGS];
    i2c_byte_t     rx_byte;
    logic [AW-1:0] ptr_inc;

    assign rx_byte = {shreg_q[6:0], sda_s};
    assign ptr_inc = ptr_q + AW'(1);

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        ptr_d         = ptr_q;
        phase_d       = phase_q;
        rw_d          = rw_q;
        sda_oe_d      = sda_oe_q;
        busy_d        = busy_q;
        regs_d        = regs_q;
        reg_wr_en_d   = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        nack_seen_d   = 1'b0;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, IGNORE: ;
                ADDR: if (scl_rise) begin
                    shreg_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rw_d    = rx_byte[0];
                        phase_d = 1'b0;
                        state_d = (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                    end
                end
                // phase 0: waiting for the fall after bit 8; phase 1: ACK being driven.
                ADDR_ACK, SUB_ACK, WR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        phase_d   = 1'b0;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        if (state_q == ADDR_ACK && rw_q) begin
                            shreg_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                            state_d  = RD_DATA;
                        end else if (state_q == ADDR_ACK) begin
                            state_d = SUB;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end
                SUB: if (scl_rise) begin
                    shreg_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
                            ptr_d   = rx_byte[AW-1:0];
                            phase_d = 1'b0;
                            state_d = SUB_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shreg_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        regs_d[ptr_q] = rx_byte;
                        reg_wr_en_d   = 1'b1;
                        reg_wr_addr_d = ptr_q;
                        reg_wr_data_d = rx_byte;
                        ptr_d         = ptr_inc;
                        phase_d       = 1'b0;
                        state_d       = WR_ACK;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        phase_d   = 1'b0;
                        state_d   = RD_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        sda_oe_d  = ~shreg_q[6];
                    end
                end
                // Next byte is fetched on the ACK rise but only driven after the following fall.
                RD_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (sda_s == I2C_NACK) begin
                            nack_seen_d = 1'b1;
                            state_d     = IGNORE;
                        end else begin
                            ptr_d   = ptr_inc;
                            shreg_d = regs_q[ptr_inc];
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        sda_oe_d  = ~shreg_q[7];
                        bit_cnt_d = '0;
                        phase_d   = 1'b0;
                        state_d   = RD_DATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            ptr_q         <= '0;
            phase_q       <= 1'b0;
            rw_q          <= 1'b0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            nack_seen_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            ptr_q         <= ptr_d;
            phase_q       <= phase_d;
            rw_q          <= rw_d;
            sda_oe_q      <= sda_oe_d;
            busy_q        <= busy_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            nack_seen_q   <= nack_seen_d;
            regs_q        <= regs_d;
        end
    end

`ifdef I2C_TARGET_STRETCH_EN
    logic        scl_oe_q, scl_oe_d;
    logic [15:0] stretch_cnt_q, stretch_cnt_d;

    // Stretch starts on every entry into RD_DATA, i.e. at the fall before each read byte.
    always_comb begin
        scl_oe_d      = scl_oe_q;
        stretch_cnt_d = stretch_cnt_q;
        if (start_det || stop_det) begin
            scl_oe_d      = 1'b0;
            stretch_cnt_d = '0;
        end else if (state_d == RD_DATA && state_q != RD_DATA) begin
            scl_oe_d      = (STRETCH_CYCLES != 0);
            stretch_cnt_d = 16'(STRETCH_CYCLES);
        end else if (scl_oe_q) begin
            if (stretch_cnt_q <= 16'd1) scl_oe_d = 1'b0;
            else stretch_cnt_d = stretch_cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_oe_q      <= 1'b0;
            stretch_cnt_q <= '0;
        end else begin
            scl_oe_q      <= scl_oe_d;
            stretch_cnt_q <= stretch_cnt_d;
        end
    end

    assign scl = scl_oe_q ? 1'b0 : 1'bz;
`else
    assign scl = 1'bz;
`endif

    assign sda            = sda_oe_q ? 1'b0 : 1'bz;
    assign rf.reg_wr_en   = reg_wr_en_q;
    assign rf.reg_wr_addr = reg_wr_addr_q;
    assign rf.reg_wr_data = reg_wr_data_q;
    assign rf.dbg_data    = regs_q[rf.dbg_addr];
    assign rf.busy        = busy_q;
    assign rf.nack_seen   = nack_seen_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bit-banged I2C master driving i2c_target_regfile, with write/read scoreboards.
module tb_i2c_target_regfile;
    import i2c_pkg::*;

    localparam int unsigned AW = 4;
    localparam int unsigned Q  = 8;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic m_scl_low = 1'b0;
    logic m_sda_low = 1'b0;
    wire  scl, sda;

    pullup (scl);
    pullup (sda);
    assign scl = m_scl_low ? 1'b0 : 1'bz;
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_target_regfile_if #(.AW(AW)) rf_if ();

    i2c_target_regfile #(
        .DEV_ADDR       (7'h48),
        .NUM_REGS       (16),
        .STRETCH_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .scl     (scl),
        .sda     (sda),
        .rf      (rf_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t         wr_q[$];
    logic [7:0]  rd_q[$];
    wr_t         wr_e;
    int unsigned cyc = 0;
    int unsigned last_rise_cyc = 0;
    int unsigned nack_cnt = 0;
    int unsigned dut_low_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rf_if.reg_wr_en) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_e = wr_q.pop_front();
                check("wr_addr", 32'(rf_if.reg_wr_addr), 32'(wr_e.addr));
                check("wr_data", 32'(rf_if.reg_wr_data), 32'(wr_e.data));
                check("wr_latency", cyc - last_rise_cyc, 32'd3);
            end
        end
        if (rf_if.nack_seen) nack_cnt++;
        if (!m_sda_low && sda === 1'b0) dut_low_cnt++;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        int n;
        m_sda_low = ~b;
        wait_q();
        m_scl_low     = 1'b0;
        last_rise_cyc = cyc;
        n = 0;
        while (scl !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("scl_release_timeout", 32'd0, 32'd1);
        wait_q();
        s = sda;
        wait_q();
        m_scl_low = 1'b1;
        wait_q();
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        wait_q();
        m_scl_low = 1'b0;
        wait_q();
        m_sda_low = 1'b1;
        wait_q();
        m_scl_low = 1'b1;
        wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        wait_q();
        m_scl_low = 1'b0;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(mack, s);
    endtask

    task automatic dbg_check(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        rf_if.dbg_addr = a;
        #1;
        check(tag, 32'(rf_if.dbg_data), 32'(exp));
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        int unsigned d0, n0;

        rf_if.dbg_addr = '0;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(rf_if.busy), 32'd0);
        check("rst_wr_en", 32'(rf_if.reg_wr_en), 32'd0);
        check("rst_nack", 32'(rf_if.nack_seen), 32'd0);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_scl", 32'(scl), 32'd1);
        reset_n = 1'b1;
        wait_q();
        dbg_check("rst_reg0", 4'd0, 8'h00);

        // Single write
        i2c_start();
        check("t1_busy", 32'(rf_if.busy), 32'd1);
        write_byte(8'h90, ack); check("t1_ack_addr", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h03, ack); check("t1_ack_sub", 32'(ack), 32'(I2C_ACK));
        wr_q.push_back('{addr: 4'd3, data: 8'hA5});
        write_byte(8'hA5, ack); check("t1_ack_data", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        wait_q();
        check("t1_busy_after_stop", 32'(rf_if.busy), 32'd0);
        check("t1_wr_drained", 32'(wr_q.size()), 32'd0);
        dbg_check("t1_reg3", 4'd3, 8'hA5);

        // Burst write with pointer wrap
        i2c_start();
        write_byte(8'h90, ack); check("t2_ack0", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h0F, ack); check("t2_ack1", 32'(ack), 32'(I2C_ACK));
        wr_q.push_back('{addr: 4'd15, data: 8'h11});
        write_byte(8'h11, ack); check("t2_ack2", 32'(ack), 32'(I2C_ACK));
        wr_q.push_back('{addr: 4'd0, data: 8'h22});
        write_byte(8'h22, ack); check("t2_ack3", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        wait_q();
        check("t2_wr_drained", 32'(wr_q.size()), 32'd0);
        dbg_check("t2_reg15", 4'd15, 8'h11);
        dbg_check("t2_reg0", 4'd0, 8'h22);

        // Seed reg4 so the read burst has a distinct second byte
        i2c_start();
        write_byte(8'h90, ack);
        write_byte(8'h04, ack);
        wr_q.push_back('{addr: 4'd4, data: 8'h5A});
        write_byte(8'h5A, ack); check("t3_ack_data", 32'(ack), 32'(I2C_ACK));
        i2c_stop();

        // Read after write with repeated START
        n0 = nack_cnt;
        i2c_start();
        write_byte(8'h90, ack);
        write_byte(8'h03, ack); check("t4_ack_sub", 32'(ack), 32'(I2C_ACK));
        i2c_start();
        write_byte(8'h91, ack); check("t4_ack_rd_addr", 32'(ack), 32'(I2C_ACK));
        rd_q.push_back(8'hA5);
        rd_q.push_back(8'h5A);
        read_byte(I2C_ACK, rb);  check("t4_rd_byte1", 32'(rb), 32'(rd_q.pop_front()));
        read_byte(I2C_NACK, rb); check("t4_rd_byte2", 32'(rb), 32'(rd_q.pop_front()));
        check("t4_nack_seen", nack_cnt - n0, 32'd1);
        d0 = dut_low_cnt;
        repeat (20) @(negedge clk);
        check("t4_sda_released", dut_low_cnt - d0, 32'd0);
        i2c_stop();

        // Read without sub-address resumes at the persisted pointer
        i2c_start();
        write_byte(8'h91, ack); check("t5_ack", 32'(ack), 32'(I2C_ACK));
        rd_q.push_back(8'h5A);
        read_byte(I2C_NACK, rb); check("t5_rd_byte", 32'(rb), 32'(rd_q.pop_front()));
        check("t5_nack_seen", nack_cnt - n0, 32'd2);
        i2c_stop();

        // Address mismatch
        d0 = dut_low_cnt;
        i2c_start();
        write_byte(8'h92, ack); check("t6_nack_addr", 32'(ack), 32'(I2C_NACK));
        write_byte(8'h55, ack); check("t6_nack_data", 32'(ack), 32'(I2C_NACK));
        check("t6_busy", 32'(rf_if.busy), 32'd1);
        i2c_stop();
        wait_q();
        check("t6_no_sda_drive", dut_low_cnt - d0, 32'd0);
        check("t6_busy_after_stop", 32'(rf_if.busy), 32'd0);

        // Out-of-range sub-address
        i2c_start();
        write_byte(8'h90, ack); check("t7_ack_addr", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h20, ack); check("t7_nack_sub", 32'(ack), 32'(I2C_NACK));
        write_byte(8'h77, ack); check("t7_nack_data", 32'(ack), 32'(I2C_NACK));
        i2c_stop();
        wait_q();
        dbg_check("t7_reg0_kept", 4'd0, 8'h22);

        // Reset while the target is driving a read data bit (reg4 = 0x5A, MSB 0)
        i2c_start();
        write_byte(8'h91, ack); check("t8_ack", 32'(ack), 32'(I2C_ACK));
        check("t8_rd_bit7_drv", 32'(sda), 32'd0);
        m_scl_low = 1'b0;
        #1;
`ifdef I2C_TARGET_STRETCH_EN
        check("t8_scl_stretched", 32'(scl), 32'd0);
`endif
        reset_n = 1'b0;
        #1;
        check("t8_sda_released", 32'(sda), 32'd1);
        check("t8_scl_released", 32'(scl), 32'd1);
        check("t8_busy", 32'(rf_if.busy), 32'd0);
        dbg_check("t8_reg3_cleared", 4'd3, 8'h00);
        dbg_check("t8_reg4_cleared", 4'd4, 8'h00);
        dbg_check("t8_reg15_cleared", 4'd15, 8'h00);
        m_sda_low = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_q();

        // Clean write after reset
        i2c_start();
        write_byte(8'h90, ack); check("t9_ack_addr", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h07, ack); check("t9_ack_sub", 32'(ack), 32'(I2C_ACK));
        wr_q.push_back('{addr: 4'd7, data: 8'hC3});
        write_byte(8'hC3, ack); check("t9_ack_data", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        wait_q();
        dbg_check("t9_reg7", 4'd7, 8'hC3);
        dbg_check("t9_reg3_zero", 4'd3, 8'h00);
        check("end_wr_drained", 32'(wr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
